// File: rtl/rob_head_advance.sv
// Purpose: reorder-buffer head pointer advancing by commit count plus skipped dead entries, never passing the tail.
// Latency: inputs sampled on a rising edge are reflected on head_o/amt_o/skip_cnt_o right after that edge; amt_v_o pulses for one cycle.
// Backpressure: none; every cycle is accepted, and the advance is clamped to the ROB occupancy instead of stalling.
module rob_head_advance #(
    parameter int RENTRIES   = 16,
    parameter int RBITS      = $clog2(RENTRIES),
    parameter int MAX_COMMIT = 4,
    parameter int MAX_SKIP   = 4,
    parameter int AMTW       = $clog2(MAX_COMMIT + MAX_SKIP + 1),
    parameter int CNTW       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [RBITS-1:0]    flush_head_i,
    input  logic                commit_v_i,
    input  logic [AMTW-1:0]     commit_amt_i,
    input  logic                skip_en_i,
    input  logic [RBITS-1:0]    rob_tail_i,
    input  logic                rob_full_i,
    input  logic [RENTRIES-1:0] rob_v_i,
    output logic [RBITS-1:0]    head_o,
    output logic [AMTW-1:0]     amt_o,
    output logic                amt_v_o,
    output logic [CNTW-1:0]     skip_cnt_o
);

    // Internal arithmetic width: holds head + a full ROB's worth of advance without overflow.
    localparam int OW = RBITS + 2;
    localparam int PW = 1 << RBITS;
    localparam logic [OW-1:0] ENT  = OW'(RENTRIES);
    localparam logic [OW-1:0] MAXC = OW'(MAX_COMMIT);

    logic [RBITS-1:0] head_q, head_d;
    logic [AMTW-1:0]  amt_q, amt_d;
    logic             amt_v_q, amt_v_d;
    logic [CNTW-1:0]  skip_cnt_q, skip_cnt_d;

    logic [OW-1:0]    occ;
    logic [OW-1:0]    c_amt;
    logic [OW-1:0]    s_amt;
    logic [OW-1:0]    probe;
    logic             skip_run;
    logic [AMTW-1:0]  t_amt;
    logic [OW-1:0]    nxt_w;
    logic [CNTW:0]    cnt_sum;
    logic [PW-1:0]    rob_v_pad;

    // Pad the valid vector to a power of two so probe indices never select out of range.
    assign rob_v_pad = PW'(rob_v_i);

    // Occupancy from head/tail distance (explicit wrap, no modulo), then commit clamped to it.
    always_comb begin
        occ = '0;
        if (rob_full_i) begin
            occ = ENT;
        end else if (rob_tail_i >= head_q) begin
            occ = OW'(rob_tail_i) - OW'(head_q);
        end else begin
            occ = OW'(rob_tail_i) + ENT - OW'(head_q);
        end
        c_amt = '0;
        if (commit_v_i) begin
            c_amt = (OW'(commit_amt_i) > MAXC) ? MAXC : OW'(commit_amt_i);
        end
        if (c_amt > occ) begin
            c_amt = occ;
        end
    end

    // Skip chain: walk past invalid entries after the committed ones; first valid entry or the tail ends it.
    always_comb begin
        s_amt    = '0;
        skip_run = skip_en_i;
        probe    = '0;
        for (int k = 0; k < MAX_SKIP; k++) begin
            probe = OW'(head_q) + c_amt + s_amt;
            if (probe >= ENT) begin
                probe = probe - ENT;
            end
            if (skip_run && ((c_amt + s_amt) < occ) && !rob_v_pad[probe[RBITS-1:0]]) begin
                s_amt = s_amt + OW'(1);
            end else begin
                skip_run = 1'b0;
            end
        end
    end

    // Next-state: flush redirect wins; otherwise advance with a single-subtract wrap and bump the saturating counter.
    always_comb begin
        t_amt      = AMTW'(c_amt + s_amt);
        nxt_w      = OW'(head_q) + OW'(t_amt);
        cnt_sum    = {1'b0, skip_cnt_q} + (CNTW + 1)'(s_amt);
        head_d     = head_q;
        amt_d      = amt_q;
        amt_v_d    = 1'b0;
        skip_cnt_d = skip_cnt_q;
        if (flush_i) begin
            head_d  = flush_head_i;
            amt_d   = '0;
            amt_v_d = 1'b0;
        end else begin
            head_d     = (nxt_w >= ENT) ? RBITS'(nxt_w - ENT) : RBITS'(nxt_w);
            amt_d      = t_amt;
            amt_v_d    = (t_amt != '0);
            skip_cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
        end
    end

    // State registers with asynchronous clear; nothing pending survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            amt_q      <= '0;
            amt_v_q    <= 1'b0;
            skip_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            amt_q      <= amt_d;
            amt_v_q    <= amt_v_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign head_o     = head_q;
    assign amt_o      = amt_q;
    assign amt_v_o    = amt_v_q;
    assign skip_cnt_o = skip_cnt_q;

    // The head must never move past the tail, and a flush target must be a real entry.
    a_no_pass_tail: assert property (@(posedge clk_i) disable iff (!rst_ni) OW'(t_amt) <= occ);
    a_flush_range:  assert property (@(posedge clk_i) disable iff (!rst_ni) flush_i |-> (OW'(flush_head_i) < ENT));

endmodule

// File: tb/tb_rob_head_advance.sv
// Bench for rob_head_advance: a 16-entry and a 10-entry instance run in lock-step.
// Both are compared every cycle against a queue-free arithmetic reference model.
// Directed scenarios first, then randomized traffic, then an asynchronous reset mid-run.
module tb_rob_head_advance;

    logic        clk;
    logic        rst_n;
    logic        flush [2];
    logic [3:0]  fh    [2];
    logic        cv    [2];
    logic [3:0]  ca    [2];
    logic        se    [2];
    logic [3:0]  tail  [2];
    logic        full  [2];
    logic [15:0] rv_a;
    logic [9:0]  rv_b;
    logic [3:0]  head_o [2];
    logic [3:0]  amt_o  [2];
    logic        amtv_o [2];
    logic [31:0] cnt_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    int     m_head [2];
    int     m_amt  [2];
    bit     m_amtv [2];
    longint m_cnt  [2];
    int     NS [2] = '{16, 10};

    rob_head_advance u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .flush_head_i(fh[0]),
        .commit_v_i(cv[0]), .commit_amt_i(ca[0]), .skip_en_i(se[0]), .rob_tail_i(tail[0]),
        .rob_full_i(full[0]), .rob_v_i(rv_a), .head_o(head_o[0]), .amt_o(amt_o[0]),
        .amt_v_o(amtv_o[0]), .skip_cnt_o(cnt_o[0])
    );

    rob_head_advance #(.RENTRIES(10)) u_dut10 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .flush_head_i(fh[1]),
        .commit_v_i(cv[1]), .commit_amt_i(ca[1]), .skip_en_i(se[1]), .rob_tail_i(tail[1]),
        .rob_full_i(full[1]), .rob_v_i(rv_b), .head_o(head_o[1]), .amt_o(amt_o[1]),
        .amt_v_o(amtv_o[1]), .skip_cnt_o(cnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: occupancy, clamped commit, then count dead entries one by one.
    function automatic void model(input int n, input int head, input bit cvi, input int cai,
                                  input bit sei, input int tl, input bit fl, input logic [15:0] v,
                                  output int nh, output int t, output int s);
        int occ, c;
        occ = fl ? n : ((tl - head + n) % n);
        c   = cvi ? ((cai > 4) ? 4 : cai) : 0;
        if (c > occ) c = occ;
        s = 0;
        if (sei)
            while (s < 4 && (c + s) < occ && v[(head + c + s) % n] == 1'b0) s++;
        t  = c + s;
        nh = (head + t) % n;
    endfunction

    task automatic cycle();
        int nh [2];
        int t  [2];
        int s  [2];
        logic [15:0] v;
        for (int d = 0; d < 2; d++) begin
            v = (d == 0) ? rv_a : {6'b0, rv_b};
            model(NS[d], m_head[d], cv[d], int'(ca[d]), se[d], int'(tail[d]), full[d], v, nh[d], t[d], s[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (flush[d]) begin
                m_head[d] = int'(fh[d]);
                m_amt[d]  = 0;
                m_amtv[d] = 1'b0;
            end else begin
                m_head[d] = nh[d];
                m_amt[d]  = t[d];
                m_amtv[d] = (t[d] != 0);
                m_cnt[d]  = m_cnt[d] + s[d];
                if (m_cnt[d] > 64'hFFFF_FFFF) m_cnt[d] = 64'hFFFF_FFFF;
            end
            chk($sformatf("d%0d_head", d), head_o[d], m_head[d]);
            chk($sformatf("d%0d_amt", d),  amt_o[d],  m_amt[d]);
            chk($sformatf("d%0d_amtv", d), amtv_o[d], m_amtv[d]);
            chk($sformatf("d%0d_cnt", d),  cnt_o[d],  m_cnt[d]);
        end
    endtask

    task automatic idle(input int d);
        flush[d] = 1'b0; cv[d] = 1'b0; se[d] = 1'b0; full[d] = 1'b0; ca[d] = 4'd0;
    endtask

    task automatic set_head(input int d, input int h);
        flush[d] = 1'b1;
        fh[d]    = 4'(h);
        cycle();
        flush[d] = 1'b0;
    endtask

    task automatic rand_inputs(input int d);
        flush[d] = ($urandom % 10) == 0;
        fh[d]    = 4'($urandom % NS[d]);
        cv[d]    = ($urandom % 4) != 0;
        ca[d]    = 4'($urandom % 16);
        se[d]    = 1'($urandom % 2);
        full[d]  = ($urandom % 8) == 0;
        tail[d]  = full[d] ? 4'(m_head[d]) : 4'($urandom % NS[d]);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            fh[d] = 4'd0; tail[d] = 4'd0;
            m_head[d] = 0; m_amt[d] = 0; m_amtv[d] = 1'b0; m_cnt[d] = 0;
        end
        rv_a = '0; rv_b = '0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_head", d), head_o[d], 0);
            chk($sformatf("rst%0d_amtv", d), amtv_o[d], 0);
            chk($sformatf("rst%0d_cnt", d),  cnt_o[d],  0);
        end
        rst_n = 1'b1;

        // commit 2 then skip two dead entries, stopped by a valid one
        set_head(0, 3);
        tail[0] = 4'd12; cv[0] = 1'b1; ca[0] = 4'd2; se[0] = 1'b1; rv_a = 16'hFF9F;
        cycle();
        chk("t2_head", head_o[0], 7);
        chk("t2_amt",  amt_o[0],  4);
        chk("t2_cnt",  cnt_o[0],  2);
        idle(0);

        // wrap on the 10-entry instance
        set_head(1, 8);
        tail[1] = 4'd5; cv[1] = 1'b1; ca[1] = 4'd3; se[1] = 1'b1; rv_b = 10'h3FD;
        cycle();
        chk("t3_head", head_o[1], 2);
        chk("t3_amt",  amt_o[1],  4);
        idle(1);

        // commit larger than occupancy, everything dead: stop at tail
        set_head(0, 2);
        tail[0] = 4'd4; cv[0] = 1'b1; ca[0] = 4'd4; se[0] = 1'b1; rv_a = 16'h0000;
        cycle();
        chk("t4_head", head_o[0], 4);
        chk("t4_amt",  amt_o[0],  2);
        chk("t4_cnt",  cnt_o[0],  2);

        // flush beats commit in the same cycle
        set_head(0, 5);
        tail[0] = 4'd12; cv[0] = 1'b1; ca[0] = 4'd3; se[0] = 1'b1;
        flush[0] = 1'b1; fh[0] = 4'd9;
        cycle();
        flush[0] = 1'b0;
        chk("t5_head", head_o[0], 9);
        chk("t5_amtv", amtv_o[0], 0);

        // skip disabled: commit only, dead entries ignored
        tail[0] = 4'd14; cv[0] = 1'b1; ca[0] = 4'd1; se[0] = 1'b0; rv_a = 16'h0000;
        cycle();
        chk("t6_amt",  amt_o[0],  1);
        chk("t6_head", head_o[0], 10);

        // empty ROB: no movement regardless of commit request
        tail[0] = 4'd10; cv[0] = 1'b1; ca[0] = 4'd2; se[0] = 1'b1;
        cycle();
        chk("t6e_head", head_o[0], 10);
        chk("t6e_amtv", amtv_o[0], 0);

        // full ROB, head == tail: commit 4 plus skip 4 across the wrap
        full[0] = 1'b1; ca[0] = 4'd4;
        cycle();
        chk("full_head", head_o[0], 2);
        chk("full_amt",  amt_o[0],  8);
        chk("full_cnt",  cnt_o[0],  6);
        idle(0);

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            rand_inputs(0);
            rand_inputs(1);
            rv_a = 16'($urandom);
            rv_b = 10'($urandom);
            cycle();
        end

        // asynchronous reset between edges
        idle(0); idle(1);
        set_head(0, 7);
        chk("rst_pre_head", head_o[0], 7);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst%0d_head", d), head_o[d], 0);
            chk($sformatf("arst%0d_amt", d),  amt_o[d],  0);
            chk($sformatf("arst%0d_amtv", d), amtv_o[d], 0);
            chk($sformatf("arst%0d_cnt", d),  cnt_o[d],  0);
            m_head[d] = 0; m_amt[d] = 0; m_amtv[d] = 1'b0; m_cnt[d] = 0;
        end
        #2 rst_n = 1'b1;

        for (int i = 0; i < 50; i++) begin
            rand_inputs(0);
            rand_inputs(1);
            rv_a = 16'($urandom);
            rv_b = 10'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
